bus_cmd_master: RTL and testbench

- Bus master sitting directly upstream of the register slaves.
- Receives a byte-serial command stream from a host link (UART RX), decodes read/write commands, and drives the 16-bit register bus.
- Waits for read data and serialises the read response back onto the host link (UART TX).
- One outstanding bus transaction at a time; includes a read-timeout guard.

---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_cmd_tx_seq.sv | 84 ++++++++
 rtl/bus_cmd_master.sv | 153 +++++++++++++++
 tb/tb_bus_cmd_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and state encoding for the register bus master
package bus_pkg;

    localparam int BUS_DW = 16;

    localparam logic [7:0] CMD_RD     = 8'h52;
    localparam logic [7:0] CMD_WR     = 8'h57;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_ADDR_HI = 4'd1;
    localparam state_t S_ADDR_LO = 4'd2;
    localparam state_t S_DATA_HI = 4'd3;
    localparam state_t S_DATA_LO = 4'd4;
    localparam state_t S_BUS_ACC = 4'd5;
    localparam state_t S_RD_WAIT = 4'd6;
    localparam state_t S_TX_STAT = 4'd7;
    localparam state_t S_TX_HI   = 4'd8;
    localparam state_t S_TX_LO   = 4'd9;
    localparam state_t S_TX_WAIT = 4'd10;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == CMD_RD) || (b == CMD_WR);
    endfunction

endpackage

// File: rtl/bus_cmd_tx_seq.sv
// rtl/bus_cmd_tx_seq.sv - serialises status, data hi, data lo onto the host TX link
module bus_cmd_tx_seq
    import bus_pkg::*;
(
    input  logic              i_Bus_Clk,
    input  logic              i_Bus_Rst_L,
    input  logic              start_i,
    input  logic [7:0]        status_i,
    input  logic [BUS_DW-1:0] data_i,
    input  logic              tx_done_i,
    output logic              tx_dv_o,
    output logic [7:0]        tx_byte_o,
    output logic              done_o
);

    state_t            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [BUS_DW-1:0] data_q, data_d;
    logic [1:0]        idx_q, idx_d;

    // Emit states last exactly one cycle; TX_WAIT holds until the link reports done
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        data_d  = data_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_TX_STAT;
                    byte_d  = status_i;
                    data_d  = data_i;
                end
            end
            S_TX_STAT: begin
                state_d = S_TX_WAIT;
                idx_d   = 2'd0;
            end
            S_TX_HI: begin
                state_d = S_TX_WAIT;
                idx_d   = 2'd1;
            end
            S_TX_LO: begin
                state_d = S_TX_WAIT;
                idx_d   = 2'd2;
            end
            S_TX_WAIT: begin
                if (tx_done_i) begin
                    case (idx_q)
                        2'd0: begin
                            state_d = S_TX_HI;
                            byte_d  = data_q[15:8];
                        end
                        2'd1: begin
                            state_d = S_TX_LO;
                            byte_d  = data_q[7:0];
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_dv_o   = (state_q == S_TX_STAT) || (state_q == S_TX_HI) || (state_q == S_TX_LO);
    assign tx_byte_o = byte_q;
    assign done_o    = (state_q == S_TX_WAIT) && (idx_q == 2'd2) && tx_done_i;

endmodule

// File: rtl/bus_cmd_master.sv
// rtl/bus_cmd_master.sv - decodes host byte commands into single register bus transactions
module bus_cmd_master
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_Bus_Rst_L,
    input  logic                  i_Bus_Clk,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Done,
    output logic                  o_Bus_CS,
    output logic                  o_Bus_Wr_Rd_n,
    output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
    output logic [BUS_DW-1:0]     o_Bus_Wr_Data,
    input  logic [BUS_DW-1:0]     i_Bus_Rd_Data,
    input  logic                  i_Bus_Rd_DV,
    output logic                  o_Rx_Drop
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_DW-1:0]     wdata_q, wdata_d;
    logic [7:0]            hi_q, hi_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  drop_q, drop_d;

    logic                  rsp_start;
    logic [7:0]            rsp_status;
    logic [BUS_DW-1:0]     rsp_data;
    logic                  rsp_done;
    logic [BUS_DW-1:0]     rx_word;

    assign rx_word = {hi_q, i_Rx_Byte};

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        drop_d     = 1'b0;
        rsp_start  = 1'b0;
        rsp_status = ST_OK;
        rsp_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && is_opcode(i_Rx_Byte)) begin
                    wr_d    = (i_Rx_Byte == CMD_WR);
                    state_d = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (i_Rx_DV) begin
                    hi_d    = i_Rx_Byte;
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (i_Rx_DV) begin
                    addr_d  = rx_word[ADDR_WIDTH-1:0];
                    state_d = wr_q ? S_DATA_HI : S_BUS_ACC;
                end
            end
            S_DATA_HI: begin
                if (i_Rx_DV) begin
                    hi_d    = i_Rx_Byte;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (i_Rx_DV) begin
                    wdata_d = rx_word;
                    state_d = S_BUS_ACC;
                end
            end
            S_BUS_ACC: begin
                drop_d  = i_Rx_DV;
                cnt_d   = CW'(1);
                state_d = wr_q ? S_IDLE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                drop_d = i_Rx_DV;
                // Read data takes priority over a timeout landing in the same cycle
                if (i_Bus_Rd_DV) begin
                    rsp_start = 1'b1;
                    rsp_data  = i_Bus_Rd_Data;
                    state_d   = S_TX_STAT;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    rsp_start  = 1'b1;
                    rsp_status = ST_TIMEOUT;
                    state_d    = S_TX_STAT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TX_STAT: begin
                // Parked here while the serialiser walks its own TX states
                drop_d = i_Rx_DV;
                if (rsp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    bus_cmd_tx_seq u_tx_seq (
        .i_Bus_Clk   (i_Bus_Clk),
        .i_Bus_Rst_L (i_Bus_Rst_L),
        .start_i     (rsp_start),
        .status_i    (rsp_status),
        .data_i      (rsp_data),
        .tx_done_i   (i_Tx_Done),
        .tx_dv_o     (o_Tx_DV),
        .tx_byte_o   (o_Tx_Byte),
        .done_o      (rsp_done)
    );

    assign o_Bus_CS      = (state_q == S_BUS_ACC);
    assign o_Bus_Wr_Rd_n = wr_q;
    assign o_Bus_Addr8   = addr_q;
    assign o_Bus_Wr_Data = wdata_q;
    assign o_Rx_Drop     = drop_q;

endmodule

// File: tb/tb_bus_cmd_master.sv
// tb/tb_bus_cmd_master.sv - scoreboard bench for the register bus command master
module tb_bus_cmd_master;

    localparam int AW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_l = 1'b1;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_done = 1'b0;
    logic          bus_cs;
    logic          bus_wr;
    logic [AW-1:0] bus_addr;
    logic [15:0]   bus_wdata;
    logic [15:0]   rd_data = '0;
    logic          rd_dv = 1'b0;
    logic          rx_drop;

    bus_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_Bus_Rst_L   (rst_l),
        .i_Bus_Clk     (clk),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Tx_DV       (tx_dv),
        .o_Tx_Byte     (tx_byte),
        .i_Tx_Done     (tx_done),
        .o_Bus_CS      (bus_cs),
        .o_Bus_Wr_Rd_n (bus_wr),
        .o_Bus_Addr8   (bus_addr),
        .o_Bus_Wr_Data (bus_wdata),
        .i_Bus_Rd_Data (rd_data),
        .i_Bus_Rd_DV   (rd_dv),
        .o_Rx_Drop     (rx_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } bus_exp_t;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } tx_exp_t;

    bus_exp_t bus_q[$];
    tx_exp_t  tx_q[$];
    int       drop_q[$];

    int          n_chk = 0;
    int          n_err = 0;
    int          last_rx = 0;
    int          last_done = -100;
    logic [15:0] model_wdata = '0;
    bit          rd_en = 1'b1;
    int          rd_delay = 1;
    logic [15:0] rd_val = '0;

    // Monitor: every DUT output event is matched against the head of its queue
    initial begin
        bus_exp_t be;
        tx_exp_t  te;
        int       want;
        forever begin
            @(negedge clk);
            if (rst_l) begin
                if (bus_cs) begin
                    n_chk++;
                    if (bus_q.size() == 0) begin
                        n_err++;
                        $display("FAIL bus_strobe: unexpected CS at cycle %0d wr=%0b addr=%0h data=%h, required none",
                                 cyc, bus_wr, bus_addr, bus_wdata);
                    end else begin
                        be = bus_q.pop_front();
                        if (bus_wr !== be.wr || bus_addr !== be.addr || bus_wdata !== be.data || cyc != be.cyc) begin
                            n_err++;
                            $display("FAIL bus_strobe: got cyc=%0d wr=%0b addr=%0h data=%h, required cyc=%0d wr=%0b addr=%0h data=%h",
                                     cyc, bus_wr, bus_addr, bus_wdata, be.cyc, be.wr, be.addr, be.data);
                        end
                    end
                end
                if (tx_dv) begin
                    n_chk++;
                    if (tx_q.size() == 0) begin
                        n_err++;
                        $display("FAIL tx_byte: unexpected TX at cycle %0d byte=%h, required none", cyc, tx_byte);
                    end else begin
                        te = tx_q.pop_front();
                        want = (te.cyc >= 0) ? te.cyc : last_done + 1;
                        if (tx_byte !== te.b || cyc != want) begin
                            n_err++;
                            $display("FAIL tx_byte: got cyc=%0d byte=%h, required cyc=%0d byte=%h",
                                     cyc, tx_byte, want, te.b);
                        end
                    end
                end
                if (rx_drop) begin
                    n_chk++;
                    if (drop_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_drop: unexpected drop pulse at cycle %0d, required none", cyc);
                    end else begin
                        want = drop_q.pop_front();
                        if (cyc != want) begin
                            n_err++;
                            $display("FAIL rx_drop: got pulse at cycle %0d, required cycle %0d", cyc, want);
                        end
                    end
                end
            end
        end
    end

    // Host transmitter model: reports done three cycles after each TX strobe
    initial begin
        forever begin
            @(negedge clk);
            if (rst_l && tx_dv) begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                tx_done   = 1'b1;
                last_done = cyc;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    // Register slave model: answers reads rd_delay cycles after the strobe
    initial begin
        forever begin
            @(negedge clk);
            if (rst_l && bus_cs && !bus_wr && rd_en) begin
                repeat (rd_delay) begin
                    @(posedge clk);
                    #1;
                end
                rd_dv   = 1'b1;
                rd_data = rd_val;
                @(posedge clk);
                #1;
                rd_dv = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        last_rx = cyc;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [15:0] d);
        bus_q.push_back('{1'b1, a, d, last_rx + 1});
        model_wdata = d;
    endtask

    task automatic exp_read(input logic [AW-1:0] a, input logic [7:0] st, input logic [15:0] d, input int dly);
        bus_q.push_back('{1'b0, a, model_wdata, last_rx + 1});
        tx_q.push_back('{st, last_rx + 2 + dly});
        tx_q.push_back('{d[15:8], -1});
        tx_q.push_back('{d[7:0], -1});
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((bus_q.size() != 0 || tx_q.size() != 0 || drop_q.size() != 0) && n < 300) begin
            idle(1);
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: expected events still pending after 300 cycles (bus=%0d tx=%0d drop=%0d), required 0",
                     nm, bus_q.size(), tx_q.size(), drop_q.size());
        end
        idle(6);
    endtask

    task automatic chk_zero(input string nm);
        n_chk++;
        if (tx_dv !== 1'b0 || tx_byte !== 8'h00 || bus_cs !== 1'b0 || bus_wr !== 1'b0 ||
            bus_addr !== '0 || bus_wdata !== 16'h0000 || rx_drop !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got tx_dv=%b tx_byte=%h cs=%b wr=%b addr=%h wdata=%h drop=%b, required all 0",
                     nm, tx_dv, tx_byte, bus_cs, bus_wr, bus_addr, bus_wdata, rx_drop);
        end
    endtask

    initial begin
        #2 rst_l = 1'b0;
        #1 chk_zero("reset_state");
        idle(3);
        rst_l = 1'b1;
        idle(2);

        send(8'h57); send(8'h00); send(8'h02); send(8'hA5); send(8'h5A);
        exp_write(2'd2, 16'hA55A);
        drain("write");

        rd_delay = 1; rd_val = 16'h1234;
        send(8'h52); send(8'h00); send(8'h00);
        exp_read(2'd0, 8'h00, 16'h1234, 1);
        drain("read_ok");

        rd_en = 1'b0;
        send(8'h52); send(8'h00); send(8'h02);
        exp_read(2'd2, 8'hEE, 16'h0000, TO);
        drain("read_timeout");
        rd_en = 1'b1;

        rd_delay = TO; rd_val = 16'hBEEF;
        send(8'h52); send(8'h00); send(8'h01);
        exp_read(2'd1, 8'h00, 16'hBEEF, TO);
        drain("read_terminal_count");
        rd_delay = 1;

        rd_val = 16'hCAFE;
        send(8'h41);
        send(8'h52); send(8'h00); send(8'h00);
        exp_read(2'd0, 8'h00, 16'hCAFE, 1);
        idle(4);
        send(8'h99);
        drop_q.push_back(last_rx + 1);
        drain("garbage_and_drop");

        send(8'h57); send(8'hFF); send(8'h07); send(8'h12); send(8'h34);
        exp_write(2'd3, 16'h1234);
        idle(1);
        send(8'h57); send(8'h00); send(8'h01); send(8'h00); send(8'h0F);
        exp_write(2'd1, 16'h000F);
        drain("back_to_back_write");

        rd_en = 1'b0;
        send(8'h52); send(8'h00); send(8'h01);
        bus_q.push_back('{1'b0, 2'd1, model_wdata, last_rx + 1});
        idle(3);
        rst_l = 1'b0;
        #1 chk_zero("reset_mid_read");
        model_wdata = 16'h0000;
        idle(2);
        rst_l = 1'b1;
        rd_en = 1'b1;
        idle(2);
        send(8'h57); send(8'h00); send(8'h00); send(8'hFF); send(8'hFF);
        exp_write(2'd0, 16'hFFFF);
        drain("write_after_reset");

        idle(TO + 20);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
